// File: rtl/spi_axi_lite_pkg.sv
// rtl/spi_axi_lite_pkg.sv - shared constants and FSM state types for the SPI AXI4-Lite register block
package spi_axi_lite_pkg;

  localparam int unsigned NUM_REGS = 4;

  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // Maps the word-select address bits onto a register index via the offset map.
  function automatic logic [1:0] reg_index(input logic [1:0] word_sel);
    logic [3:0] byte_off;
    byte_off = {word_sel, 2'b00};
    case (byte_off)
      REG0_OFFSET: reg_index = 2'd0;
      REG1_OFFSET: reg_index = 2'd1;
      REG2_OFFSET: reg_index = 2'd2;
      REG3_OFFSET: reg_index = 2'd3;
      default:     reg_index = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/spi_axi_lite_wstrb_merge.sv
// rtl/spi_axi_lite_wstrb_merge.sv - byte-lane merge of old register value with write data under WSTRB
module spi_axi_lite_wstrb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  // Each strobe bit selects the new byte; unstrobed lanes keep the old byte.
  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wstrb_i[b]) begin
        merged_o[b*8 +: 8] = wdata_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/spi_axi_lite_regs.sv
// rtl/spi_axi_lite_regs.sv - AXI4-Lite slave with four read/write registers feeding the SPI engine
module spi_axi_lite_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o
);

  import spi_axi_lite_pkg::*;

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  // Register file, word 0 in the low bits so it maps straight onto regs_o.
  logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;

  // Write channel state.
  w_state_e        w_state_q, w_state_d;
  logic            aw_latched_q, aw_latched_d;
  logic            w_latched_q, w_latched_d;
  logic [1:0]      awidx_q, awidx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;

  // Read channel state.
  r_state_e        r_state_q, r_state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            aw_hs, w_hs, have_aw, have_w;
  logic [1:0]      commit_idx;
  logic [DW-1:0]   commit_data, merged;
  logic [SW-1:0]   commit_strb;

  // Protection bits and sub-word address bits carry no meaning for this block.
  logic            unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready flags are only ever set in the idle states, so they double as state qualifiers.
  assign aw_hs   = S_AXI_AWVALID & awready_q;
  assign w_hs    = S_AXI_WVALID & wready_q;
  assign have_aw = aw_latched_q | aw_hs;
  assign have_w  = w_latched_q | w_hs;

  // A handshake in the committing cycle takes priority over the (empty) latch.
  assign commit_idx  = aw_hs ? reg_index(S_AXI_AWADDR[3:2]) : awidx_q;
  assign commit_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign commit_strb = w_hs ? S_AXI_WSTRB : wstrb_q;

  spi_axi_lite_wstrb_merge #(
    .DATA_WIDTH(DW)
  ) u_wstrb_merge (
    .old_i    (regs_q[commit_idx]),
    .wdata_i  (commit_data),
    .wstrb_i  (commit_strb),
    .merged_o (merged)
  );

  // Write FSM next state: collect AW and W in any order, commit once both are present.
  always_comb begin
    w_state_d    = w_state_q;
    aw_latched_d = aw_latched_q;
    w_latched_d  = w_latched_q;
    awidx_d      = awidx_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    regs_d       = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_latched_d = 1'b1;
          awidx_d      = reg_index(S_AXI_AWADDR[3:2]);
        end
        if (w_hs) begin
          w_latched_d = 1'b1;
          wdata_d     = S_AXI_WDATA;
          wstrb_d     = S_AXI_WSTRB;
        end
        if (have_aw && have_w) begin
          regs_d[commit_idx] = merged;
          bvalid_d           = 1'b1;
          awready_d          = 1'b0;
          wready_d           = 1'b0;
          w_state_d          = W_RESP;
        end else begin
          awready_d = ~have_aw;
          wready_d  = ~have_w;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d     = 1'b0;
          aw_latched_d = 1'b0;
          w_latched_d  = 1'b0;
          awready_d    = 1'b1;
          wready_d     = 1'b1;
          w_state_d    = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM and register file state; reset aborts any transaction in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q    <= W_IDLE;
      aw_latched_q <= 1'b0;
      w_latched_q  <= 1'b0;
      awidx_q      <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      regs_q       <= '0;
    end else begin
      w_state_q    <= w_state_d;
      aw_latched_q <= aw_latched_d;
      w_latched_q  <= w_latched_d;
      awidx_q      <= awidx_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      regs_q       <= regs_d;
    end
  end

  // Read FSM next state: sample the pre-edge register value and hold it until taken.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          rdata_d   = regs_q[reg_index(S_AXI_ARADDR[3:2])];
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign regs_o        = regs_q;

endmodule
